alu_mul_seq: RTL and testbench

Multi-cycle 32x32 -> 64-bit multiplier sequencer built around the team's 32-bit ALU (ALU_32bit), which serves as its only adder/subtractor. It runs radix-2 Booth for signed operands and shift-add for unsigned operands, one ALU pass per cycle, 32 passes per product. It uses a start/ready request handshake and a valid/ack result handshake. It sits beside the main ALU in the execute stage and serves mult/multu.

---
 rtl/alu_mul_seq_pkg.sv | 25 ++
 rtl/alu_mul_seq_alu.sv | 43 ++++
 rtl/alu_mul_seq.sv | 135 +++++++++++++
 tb/tb_alu_mul_seq.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/alu_mul_seq_pkg.sv
// Shared encodings for the sequential multiplier and the 32-bit ALU it drives.
// Holds the ALU operation codes, the controller states and the iteration count.
package alu_mul_seq_pkg;

  localparam logic [1:0] OP_AND = 2'd0;
  localparam logic [1:0] OP_OR  = 2'd1;
  localparam logic [1:0] OP_ADD = 2'd2;
  localparam logic [1:0] OP_SLT = 2'd3;

  localparam int MUL_ITER = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  // Per-cycle action on the partial product high word.
  typedef enum logic [1:0] {
    MOP_PASS = 2'd0,
    MOP_ADD  = 2'd1,
    MOP_SUB  = 2'd2
  } mul_op_e;

endpackage

// File: rtl/alu_mul_seq_alu.sv
// 32-bit ALU (AND/OR/ADD/SLT) with operand inversion, carry-in, carry-out and
// an overflow-corrected sign output usable as the true sign of a signed add.
module ALU_32bit
  import alu_mul_seq_pkg::*;
(
  input  logic [31:0] src1_i,
  input  logic [31:0] src2_i,
  input  logic        a_invert_i,
  input  logic        b_invert_i,
  input  logic        cin_i,
  input  logic [1:0]  operation_i,
  input  logic        less_i,
  output logic [31:0] result_o,
  output logic        cout_o,
  output logic        sign_o
);

  logic [31:0] w_a;
  logic [31:0] w_b;
  logic [32:0] w_sum;
  logic        w_ovf;

  assign w_a   = a_invert_i ? ~src1_i : src1_i;
  assign w_b   = b_invert_i ? ~src2_i : src2_i;
  assign w_sum = {1'b0, w_a} + {1'b0, w_b} + {32'b0, cin_i};
  assign w_ovf = (w_a[31] == w_b[31]) && (w_sum[31] != w_a[31]);

  assign cout_o = w_sum[32];
  assign sign_o = w_sum[31] ^ w_ovf;

  // less_i feeds the upper bit slices in SLT mode; bit 0 carries the set result.
  always_comb begin
    result_o = '0;
    case (operation_i)
      OP_AND:  result_o = w_a & w_b;
      OP_OR:   result_o = w_a | w_b;
      OP_ADD:  result_o = w_sum[31:0];
      OP_SLT:  result_o = {{31{less_i}}, sign_o};
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_mul_seq.sv
// Multi-cycle 32x32->64 multiplier: radix-2 Booth (signed) or shift-add
// (unsigned), one pass through the shared 32-bit ALU per cycle.
module alu_mul_seq
  import alu_mul_seq_pkg::*;
#(
  parameter int DATA_W = 32,  // tied to the ALU width; other values unsupported
  parameter int CNT_W  = 5
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                signed_i,
  input  logic [DATA_W-1:0]   src1_i,
  input  logic [DATA_W-1:0]   src2_i,
  output logic                ready_o,
  output logic                busy_o,
  output logic                valid_o,
  input  logic                ack_i,
  output logic [2*DATA_W-1:0] prod_o
);

  // Handshakes: a request transfers on an edge where start_i && ready_o; a
  // result transfers on an edge where valid_o && ack_i. valid_o and prod_o
  // stay put until that transfer.

  mul_state_e        r_state;
  mul_state_e        w_state_nxt;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;
  logic [DATA_W-1:0] r_mcand;
  logic              r_q1;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_signed;

  mul_op_e           w_mop;
  logic [DATA_W-1:0] w_alu_src2;
  logic              w_alu_binv;
  logic              w_alu_cin;
  logic [DATA_W-1:0] w_sum;
  logic              w_cout;
  logic              w_sign;
  logic              w_top;
  logic              w_last;

  assign w_last = (r_cnt == CNT_W'(MUL_ITER - 1));

  always_comb begin
    w_mop = MOP_PASS;
    if (r_signed) begin
      case ({r_lo[0], r_q1})
        2'b01:   w_mop = MOP_ADD;
        2'b10:   w_mop = MOP_SUB;
        default: w_mop = MOP_PASS;
      endcase
    end else if (r_lo[0]) begin
      w_mop = MOP_ADD;
    end
  end

  assign w_alu_src2 = (w_mop == MOP_PASS) ? '0 : r_mcand;
  assign w_alu_binv = (w_mop == MOP_SUB);
  assign w_alu_cin  = (w_mop == MOP_SUB);

  ALU_32bit u_alu (
    .src1_i      (r_hi),
    .src2_i      (w_alu_src2),
    .a_invert_i  (1'b0),
    .b_invert_i  (w_alu_binv),
    .cin_i       (w_alu_cin),
    .operation_i (OP_ADD),
    .less_i      (1'b0),
    .result_o    (w_sum),
    .cout_o      (w_cout),
    .sign_o      (w_sign)
  );

  // Bit shifted into hi: true sign for Booth's arithmetic shift, carry for unsigned.
  assign w_top = r_signed ? w_sign : w_cout;

  always_comb begin
    w_state_nxt = r_state;
    ready_o     = 1'b0;
    busy_o      = 1'b0;
    valid_o     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ready_o = 1'b1;
        if (start_i) w_state_nxt = ST_CALC;
      end
      ST_CALC: begin
        busy_o = 1'b1;
        if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        valid_o = 1'b1;
        if (ack_i) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_mcand  <= '0;
      r_q1     <= 1'b0;
      r_cnt    <= '0;
      r_signed <= 1'b0;
    end else if (r_state == ST_IDLE && start_i) begin
      r_mcand  <= src1_i;
      r_lo     <= src2_i;
      r_hi     <= '0;
      r_q1     <= 1'b0;
      r_cnt    <= '0;
      r_signed <= signed_i;
    end else if (r_state == ST_CALC) begin
      r_hi  <= {w_top, w_sum[DATA_W-1:1]};
      r_lo  <= {w_sum[0], r_lo[DATA_W-1:1]};
      r_q1  <= r_lo[0];
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign prod_o = {r_hi, r_lo};

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: directed corner products, handshake
// timing, ignored requests, async reset and a randomized regression.
module tb_alu_mul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sgn;
  logic [31:0] a;
  logic [31:0] b;
  logic        ack;
  logic        ready_o;
  logic        busy_o;
  logic        valid_o;
  logic [63:0] prod_o;

  int n_cmp = 0;
  int n_err = 0;

  alu_mul_seq dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .signed_i (sgn),
    .src1_i   (a),
    .src2_i   (b),
    .ready_o  (ready_o),
    .busy_o   (busy_o),
    .valid_o  (valid_o),
    .ack_i    (ack),
    .prod_o   (prod_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // reference: full-precision product by plain 64-bit arithmetic
  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                          input logic s);
    longint      sx;
    longint      sy;
    logic [63:0] ux;
    logic [63:0] uy;
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    ux = {32'b0, x};
    uy = {32'b0, y};
    return ux * uy;
  endfunction

  // scoreboard of expected products
  logic [63:0] exp_q[$];

  // driver: one multiply; ack_delay=0 means ack held high throughout
  task automatic do_mul(input logic [31:0] x, input logic [31:0] y, input logic s,
                        input int ack_delay, input bit poke, input string tag);
    int          n;
    int          busy_n;
    logic [63:0] exp;
    logic [63:0] held;
    n = 0;
    busy_n = 0;
    exp_q.push_back(ref_mul(x, y, s));
    @(negedge clk);
    a = x; b = y; sgn = s; start = 1'b1;
    ack = (ack_delay == 0);
    check({tag, "_rdy_pre"}, 64'(ready_o), 64'd1);
    @(posedge clk); #1;
    start = 1'b0;
    while (!valid_o && n < 100) begin
      if (busy_o) busy_n++;
      if (poke) begin
        start = (n == 10);
        if (n == 10) begin a = ~x; b = y + 32'd3; sgn = ~s; end
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    exp = exp_q.pop_front();
    check({tag, "_lat"}, 64'(n + 1), 64'd33);
    check({tag, "_busy"}, 64'(busy_n), 64'd32);
    check({tag, "_prod"}, prod_o, exp);
    if (ack_delay > 0) begin
      held = prod_o;
      for (int i = 0; i < ack_delay; i++) begin
        if (poke) begin start = 1'b1; a = $urandom; b = $urandom; end
        @(posedge clk); #1;
        check({tag, "_hold_v"}, 64'(valid_o), 64'd1);
        check({tag, "_hold_p"}, prod_o, held);
      end
      start = 1'b0;
      @(negedge clk);
      ack = 1'b1;
    end
    @(posedge clk); #1;
    ack = 1'b0;
    check({tag, "_rdy_post"}, 64'(ready_o), 64'd1);
    check({tag, "_v_post"}, 64'(valid_o), 64'd0);
  endtask

  task automatic reset_mid_calc();
    @(negedge clk);
    a = 32'd1234; b = 32'd5678; sgn = 1'b0; start = 1'b1; ack = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("rst_mid_ready", 64'(ready_o), 64'd1);
    check("rst_mid_busy", 64'(busy_o), 64'd0);
    check("rst_mid_valid", 64'(valid_o), 64'd0);
    check("rst_mid_prod", prod_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sgn = 1'b0; a = '0; b = '0; ack = 1'b0;
    #2;
    check("rst_ready", 64'(ready_o), 64'd1);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_prod", prod_o, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_mul(32'd7, 32'd6, 1'b0, 0, 1'b0, "u7x6");
    check("u7x6_const", prod_o, 64'h0000_0000_0000_002A);
    do_mul(32'hFFFF_FFFD, 32'd5, 1'b1, 1, 1'b0, "sm3x5");
    do_mul(32'h8000_0000, 32'h8000_0000, 1'b1, 1, 1'b0, "smin2");
    check("smin2_const", prod_o, 64'h4000_0000_0000_0000);
    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1, 1'b0, "umax2");
    check("umax2_const", prod_o, 64'hFFFF_FFFE_0000_0001);
    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1, 1'b0, "sm1m1");
    check("sm1m1_const", prod_o, 64'h0000_0000_0000_0001);
    do_mul(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 10, 1'b1, "poke");

    reset_mid_calc();
    do_mul(32'd12, 32'd12, 1'b0, 0, 1'b0, "u12x12");
    check("u12x12_const", prod_o, 64'h0000_0000_0000_0090);

    for (int k = 0; k < 1500; k++) begin
      logic [31:0] rx;
      logic [31:0] ry;
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(0, 3))
        0: rx = 32'h8000_0000;
        1: ry = $urandom_range(0, 15);
        default: ;
      endcase
      do_mul(rx, ry, 1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'b0, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
